// File: rtl/down_counter_timer_if.sv
// Control/status bundle for down_counter_timer: load/start/stop/tick requests in,
// registered count, busy and terminal-count pulse out.
interface down_counter_timer_if #(
    parameter int N = 8
);
    logic         load;
    logic [N-1:0] load_value;
    logic         start;
    logic         stop;
    logic         enable;
    logic [N-1:0] Q;
    logic         busy;
    logic         done;

    modport master (
        output load, load_value, start, stop, enable,
        input  Q, busy, done
    );

    modport slave (
        input  load, load_value, start, stop, enable,
        output Q, busy, done
    );
endinterface

// File: rtl/down_counter_timer.sv
// Loadable down-counting timer with start/stop and a one-cycle terminal-count pulse.
// Define DOWN_COUNTER_TIMER_AUTO_RELOAD_EN to reload from reload_reg at terminal count.
module down_counter_timer #(
    parameter int N = 8
) (
    input  logic               clk,
    input  logic               rst,
    down_counter_timer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t       state, state_nxt;
    logic [N-1:0] q, q_nxt;
    logic [N-1:0] reload_reg, reload_nxt;
    logic         busy_q, done_q, done_nxt;
    logic         at_terminal;

    // Q=0 can only reach RUN via a zero load during PAUSE; treat it as terminal
    // so the counter can never stick in RUN.
    assign at_terminal = (q <= N'(1));

    always_comb begin
        state_nxt  = state;
        q_nxt      = q;
        reload_nxt = reload_reg;
        done_nxt   = 1'b0;

        if (bus.load) begin
            q_nxt      = bus.load_value;
            reload_nxt = bus.load_value;
            if (state == RUN && bus.load_value == '0) begin
                state_nxt = IDLE;
                done_nxt  = 1'b1;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (q != '0) state_nxt = RUN;
                        else         done_nxt  = 1'b1;
                    end
                end
                RUN: begin
                    if (bus.stop) begin
                        state_nxt = PAUSE;
                    end else if (bus.enable) begin
                        if (!at_terminal) begin
                            q_nxt = q - N'(1);
                        end else begin
                            done_nxt = 1'b1;
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
                            q_nxt     = reload_reg;
`else
                            q_nxt     = '0;
                            state_nxt = IDLE;
`endif
                        end
                    end
                end
                PAUSE: begin
                    if (bus.start && !bus.stop) state_nxt = RUN;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            q          <= '0;
            reload_reg <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state      <= state_nxt;
            q          <= q_nxt;
            reload_reg <= reload_nxt;
            busy_q     <= (state_nxt != IDLE);
            done_q     <= done_nxt;
        end
    end

    assign bus.Q    = q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_down_counter_timer.sv
// Directed bench for down_counter_timer; covers both builds via the reload macro.
module tb_down_counter_timer;
    logic clk;
    logic rst;
    int   vectors;
    int   errs;

    down_counter_timer_if #(.N(8)) bus ();

    down_counter_timer #(.N(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int q, input int b, input int d);
        chk({tag, ".Q"}, 32'(bus.Q), 32'(q));
        chk({tag, ".busy"}, 32'(bus.busy), 32'(b));
        chk({tag, ".done"}, 32'(bus.done), 32'(d));
    endtask

    task automatic idle_inputs();
        bus.load = 1'b0; bus.load_value = '0; bus.start = 1'b0;
        bus.stop = 1'b0; bus.enable = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic load_start(input int v);
        bus.load = 1'b1; bus.load_value = 8'(v);
        tick();
        bus.load = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    initial begin
        vectors = 0;
        errs    = 0;
        idle_inputs();
        rst = 1'b0;
        #12;
        chk_out("reset", 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;

        // zero-length start
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk_out("zstart", 0, 0, 1);
        tick();
        chk_out("zstart+1", 0, 0, 0);

        // basic count from 5
        do_reset();
        load_start(5);
        chk_out("basic.start", 5, 1, 0);
        bus.enable = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk_out($sformatf("basic.k%0d", k), 5 - k, 1, 0);
        end
        tick();
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
        chk_out("basic.term", 5, 1, 1);
`else
        chk_out("basic.term", 0, 0, 1);
`endif
        tick();
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
        chk_out("basic.after", 4, 1, 0);
`else
        chk_out("basic.after", 0, 0, 0);
`endif

        // pause/resume with gapped enable
        do_reset();
        load_start(8);
        for (int k = 0; k < 5; k++) begin
            bus.enable = (k % 2 == 0);
            tick();
        end
        chk_out("gap.pre", 5, 1, 0);
        bus.stop = 1'b1; bus.enable = 1'b1;
        tick();
        bus.stop = 1'b0;
        chk_out("pause.0", 5, 1, 0);
        for (int k = 1; k < 6; k++) begin
            tick();
            chk_out($sformatf("pause.%0d", k), 5, 1, 0);
        end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk_out("resume", 5, 1, 0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk_out($sformatf("resume.k%0d", k), 5 - k, 1, 0);
        end
        tick();
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
        chk_out("gap.term", 8, 1, 1);
`else
        chk_out("gap.term", 0, 0, 1);
`endif
        bus.enable = 1'b0;

        // priority collisions
        do_reset();
        load_start(10);
        bus.enable = 1'b1;
        tick();
        chk_out("prio.run", 9, 1, 0);
        bus.load = 1'b1; bus.load_value = 8'd20; bus.stop = 1'b1; bus.start = 1'b1;
        tick();
        bus.load = 1'b0;
        chk_out("prio.A", 20, 1, 0);
        tick();
        bus.stop = 1'b0; bus.start = 1'b0;
        chk_out("prio.B", 20, 1, 0);
        tick();
        chk_out("prio.B.hold", 20, 1, 0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        chk_out("prio.resumed", 19, 1, 0);
        bus.load = 1'b1; bus.load_value = 8'd0;
        tick();
        bus.load = 1'b0;
        chk_out("prio.C", 0, 0, 1);
        tick();
        chk_out("prio.C+1", 0, 0, 0);
        bus.enable = 1'b0;

        // asynchronous reset mid-count
        do_reset();
        load_start(10);
        bus.enable = 1'b1;
        repeat (4) tick();
        chk_out("arst.pre", 6, 1, 0);
        #2;
        rst = 1'b0;
        #1;
        chk_out("arst.async", 0, 0, 0);
        tick();
        rst = 1'b1;
        tick();
        chk_out("arst.rel", 0, 0, 0);
        tick();
        chk_out("arst.rel+1", 0, 0, 0);
        bus.enable = 1'b0;

`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
        begin
            int pulses;
            pulses = 0;
            do_reset();
            load_start(3);
            bus.enable = 1'b1;
            for (int k = 1; k <= 12; k++) begin
                tick();
                if (bus.done) pulses++;
                chk_out($sformatf("reload.k%0d", k),
                        (k % 3 == 0) ? 3 : 3 - (k % 3), 1, (k % 3 == 0) ? 1 : 0);
            end
            chk("reload.pulses", 32'(pulses), 32'd4);
            bus.enable = 1'b0;
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
